ts_mixer: RTL

Turbosound output mixer. It sits directly downstream of the dual-YM2203 Turbosound block and consumes its six 8-bit SSG channels, two signed 16-bit FM outputs and the FM-enable flag. On each sample strobe it snapshots all inputs and accumulates them serially, one term per clock, into left/right accumulators using the selected stereo panning. It then saturates the result to signed 16-bit stereo for the audio DAC/codec path.

---
 rtl/ts_mixer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ts_mixer.sv
// ts_mixer: Turbosound output mixer.
// On a sample strobe the block snapshots both chips' PSG channels, FM samples,
// the FM-enable flag and the panning mode. It then accumulates one term per
// clock into 18-bit left/right accumulators and saturates the result to
// signed 16-bit stereo.
//
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   ce_sample            one-cycle strobe requesting a new mix
//   stereo_mode          00/11 = ABC, 01 = ACB, 10 = mono
//   ssg{0,1}_audio_{a,b,c}  unsigned 8-bit PSG channels
//   ssg{0,1}_audio_fm    signed 16-bit FM samples
//   ssg_fm_ena           FM terms forced to zero when low
//   audio_l, audio_r     saturated signed mix, held between updates
//   audio_valid          one-cycle pulse marking a new audio_l/audio_r
//   busy                 high while a mix is in progress
//   overrun              one-cycle pulse when a strobe is dropped
module ts_mixer #(
    parameter int unsigned FM_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_sample,
    input  logic [1:0]  stereo_mode,
    input  logic [7:0]  ssg0_audio_a,
    input  logic [7:0]  ssg0_audio_b,
    input  logic [7:0]  ssg0_audio_c,
    input  logic [7:0]  ssg1_audio_a,
    input  logic [7:0]  ssg1_audio_b,
    input  logic [7:0]  ssg1_audio_c,
    input  logic [15:0] ssg0_audio_fm,
    input  logic [15:0] ssg1_audio_fm,
    input  logic        ssg_fm_ena,
    output logic [15:0] audio_l,
    output logic [15:0] audio_r,
    output logic        audio_valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e             state;
    logic [2:0]         step;
    logic signed [17:0] acc_l;
    logic signed [17:0] acc_r;

    // Snapshot taken on the accepted strobe.
    logic [7:0]  snap_a0, snap_b0, snap_c0;
    logic [7:0]  snap_a1, snap_b1, snap_c1;
    logic [15:0] snap_fm0, snap_fm1;
    logic        snap_fm_ena;
    logic [1:0]  snap_mode;

    // Current step's term.
    logic [7:0]         psg_v;
    logic [1:0]         chan;      // 0 = A, 1 = B, 2 = C
    logic signed [15:0] fm_raw;
    logic signed [15:0] fm_shr;
    logic signed [17:0] fm_ext;
    logic signed [17:0] psg_full;
    logic signed [17:0] psg_half;
    logic signed [17:0] term_l;
    logic signed [17:0] term_r;

    always_comb begin
        psg_v  = '0;
        chan   = 2'd0;
        fm_raw = '0;
        case (step)
            3'd0: begin psg_v = snap_a0; chan = 2'd0; end
            3'd1: begin psg_v = snap_b0; chan = 2'd1; end
            3'd2: begin psg_v = snap_c0; chan = 2'd2; end
            3'd3: begin psg_v = snap_a1; chan = 2'd0; end
            3'd4: begin psg_v = snap_b1; chan = 2'd1; end
            3'd5: begin psg_v = snap_c1; chan = 2'd2; end
            3'd6: fm_raw = snap_fm0;
            3'd7: fm_raw = snap_fm1;
            default: ;
        endcase
    end

    assign fm_shr   = fm_raw >>> FM_SHIFT;
    assign fm_ext   = {{2{fm_shr[15]}}, fm_shr};
    assign psg_full = {5'b0, psg_v, 5'b0};
    assign psg_half = {6'b0, psg_v, 4'b0};

    always_comb begin
        term_l = '0;
        term_r = '0;
        if (step < 3'd6) begin
            case (snap_mode)
                2'b10: begin
                    term_l = psg_half;
                    term_r = psg_half;
                end
                2'b01: begin
                    // ACB: A left, B right, C centre.
                    case (chan)
                        2'd0:    term_l = psg_full;
                        2'd1:    term_r = psg_full;
                        default: begin
                            term_l = psg_half;
                            term_r = psg_half;
                        end
                    endcase
                end
                default: begin
                    // ABC: A left, C right, B centre.
                    case (chan)
                        2'd0:    term_l = psg_full;
                        2'd2:    term_r = psg_full;
                        default: begin
                            term_l = psg_half;
                            term_r = psg_half;
                        end
                    endcase
                end
            endcase
        end else if (snap_fm_ena) begin
            term_l = fm_ext;
            term_r = fm_ext;
        end
    end

    function automatic logic [15:0] clamp18(input logic signed [17:0] v);
        if (v > 18'sd32767) begin
            return 16'h7fff;
        end else if (v < -18'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

    assign busy = (state != StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StIdle;
            step        <= '0;
            acc_l       <= '0;
            acc_r       <= '0;
            snap_a0     <= '0;
            snap_b0     <= '0;
            snap_c0     <= '0;
            snap_a1     <= '0;
            snap_b1     <= '0;
            snap_c1     <= '0;
            snap_fm0    <= '0;
            snap_fm1    <= '0;
            snap_fm_ena <= 1'b0;
            snap_mode   <= '0;
            audio_l     <= '0;
            audio_r     <= '0;
            audio_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            audio_valid <= 1'b0;
            overrun     <= 1'b0;
            case (state)
                StIdle: begin
                    if (ce_sample) begin
                        snap_a0     <= ssg0_audio_a;
                        snap_b0     <= ssg0_audio_b;
                        snap_c0     <= ssg0_audio_c;
                        snap_a1     <= ssg1_audio_a;
                        snap_b1     <= ssg1_audio_b;
                        snap_c1     <= ssg1_audio_c;
                        snap_fm0    <= ssg0_audio_fm;
                        snap_fm1    <= ssg1_audio_fm;
                        snap_fm_ena <= ssg_fm_ena;
                        snap_mode   <= stereo_mode;
                        acc_l       <= '0;
                        acc_r       <= '0;
                        step        <= '0;
                        state       <= StAcc;
                    end
                end
                StAcc: begin
                    overrun <= ce_sample;
                    acc_l   <= acc_l + term_l;
                    acc_r   <= acc_r + term_r;
                    step    <= step + 3'd1;
                    if (step == 3'd7) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    overrun     <= ce_sample;
                    audio_l     <= clamp18(acc_l);
                    audio_r     <= clamp18(acc_r);
                    audio_valid <= 1'b1;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
